uart_tx_frame: RTL

//  Parametrised UART serialiser; generalised successor of the 8-bit pass-through transmitter.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_tx_frame.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes and the frame FSM state encoding.
// Used by the transmitter now and intended for the receiver as well.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. 'clear' holds the count at zero so that a frame starts
// on a clean bit boundary.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign tick = (cnt_reg == LAST_CNT);

  // Free-running bit-period counter, wraps to zero after the terminal count.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: one word per valid/ready handshake, sent as
// start bit, DATA_BITS data bits LSB-first, optional parity, 1 or 2 stop bits.
// The serial line is a registered output so it never glitches.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  // Refuse to build with parameters the framing logic does not support.
  if ((DATA_BITS < 5) || (DATA_BITS > 9) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
      (PARITY_MODE < PARITY_NONE) || (PARITY_MODE > PARITY_ODD) || (CLKS_PER_BIT < 2)) begin : g_bad_param
    $fatal(1, "uart_tx_frame: illegal parameter combination");
  end

  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam bit HAS_PARITY = (PARITY_MODE != PARITY_NONE);

  uart_state_t          state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic                 parity_reg, parity_next;
  logic                 tx_reg, tx_next;
  logic                 baud_clear;
  logic                 baud_tick;

  // The baud timer sits at zero while idle, so START lasts a full bit period.
  assign baud_clear = (state_reg == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (baud_tick)
  );

  assign tx_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign tx       = tx_reg;

  // Next-state, datapath and frame_done decode; tx is derived from the next
  // state so the line flop changes on the same edge as the FSM.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    parity_next  = parity_reg;
    frame_done   = 1'b0;
    tx_next      = 1'b1;

    case (state_reg)
      IDLE: begin
        if (tx_valid) begin
          state_next   = START;
          shift_next   = tx_data;
          bit_cnt_next = '0;
          parity_next  = (PARITY_MODE == PARITY_ODD) ? ~^tx_data : ^tx_data;
        end
      end
      START: begin
        if (baud_tick) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == LAST_DATA) begin
            bit_cnt_next = '0;
            state_next   = HAS_PARITY ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_next   = STOP;
          bit_cnt_next = '0;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (bit_cnt_reg == LAST_STOP) begin
            state_next = IDLE;
            frame_done = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
  end

  // State, shift register, bit counter, parity and line registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      parity_reg  <= 1'b0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      parity_reg  <= parity_next;
      tx_reg      <= tx_next;
    end
  end

endmodule
